// File: rtl/instr_decode_pkg.sv
// Shared opcode/funct constants, format codes and the decoded-field bundle
// used by the MIPS-32 decode stage.
package instr_decode_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [4:0] RA_REG = 5'd31;

  typedef enum logic [1:0] {
    FMT_R = 2'd0,
    FMT_I = 2'd1,
    FMT_J = 2'd2
  } fmt_t;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] src1;
    logic [4:0] src2;
    logic [4:0] dest;
    logic [4:0] shamt;
    logic [5:0] funct;
    fmt_t       fmt;
    logic       writes_reg;
    logic       illegal;
  } dec_fields_t;

  localparam int DEC_W = $bits(dec_fields_t);

  // Logical immediates are the only ones that may be zero-extended.
  function automatic logic is_logic_imm(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/instr_decode_comb.sv
// Purely combinational MIPS-32 field decoder: instruction word and pc in,
// decoded narrow fields plus extended immediate and jump target out.
module instr_decode_comb
  import instr_decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ZERO_EXT_LOGIC = 1
) (
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  output logic [DEC_W-1:0] fields,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  jtarget
);

  dec_fields_t     f_s;
  logic [5:0]      op_s;
  logic [XLEN-1:0] pc4_s;
  logic [XLEN-1:0] jt_calc_s;
  logic [XLEN-1:0] imm_sext_s;
  logic [XLEN-1:0] imm_zext_s;
  logic [XLEN-1:0] imm_lui_s;
  logic [XLEN-1:0] imm_i_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] jt_s;
  logic            unused_pc4_s;

  assign op_s       = instr[31:26];
  assign pc4_s      = pc + XLEN'(3'd4);
  assign jt_calc_s  = {pc4_s[XLEN-1:28], instr[25:0], 2'b00};
  assign unused_pc4_s = ^pc4_s[27:0];

  assign imm_sext_s = XLEN'($signed(instr[15:0]));
  assign imm_zext_s = XLEN'(instr[15:0]);
  assign imm_lui_s  = XLEN'($signed({instr[15:0], 16'h0000}));

  // Immediate extension choice for I-format opcodes.
  always_comb begin
    imm_i_s = imm_sext_s;
    if (op_s == OP_LUI) begin
      imm_i_s = imm_lui_s;
    end else if ((ZERO_EXT_LOGIC != 0) && is_logic_imm(op_s)) begin
      imm_i_s = imm_zext_s;
    end else begin
      imm_i_s = imm_sext_s;
    end
  end

  // Opcode-driven field decode; unsupported opcodes fall to the illegal arm.
  always_comb begin
    f_s        = '0;
    imm_s      = '0;
    jt_s       = '0;
    f_s.opcode = op_s;
    f_s.src1   = instr[25:21];
    f_s.fmt    = FMT_I;
    case (op_s)
      OP_RTYPE: begin
        f_s.fmt        = FMT_R;
        f_s.src2       = instr[20:16];
        f_s.shamt      = instr[10:6];
        f_s.funct      = instr[5:0];
        f_s.writes_reg = (instr[5:0] != FN_JR);
        if (f_s.writes_reg) begin
          f_s.dest = instr[15:11];
        end else begin
          f_s.dest = 5'd0;
        end
      end
      OP_J: begin
        f_s.fmt = FMT_J;
        jt_s    = jt_calc_s;
      end
      OP_JAL: begin
        f_s.fmt        = FMT_J;
        f_s.writes_reg = 1'b1;
        f_s.dest       = RA_REG;
        jt_s           = jt_calc_s;
      end
      OP_BEQ, OP_BNE, OP_SW: begin
        f_s.src2 = instr[20:16];
        imm_s    = imm_i_s;
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW: begin
        f_s.writes_reg = 1'b1;
        f_s.dest       = instr[20:16];
        imm_s          = imm_i_s;
      end
      default: begin
        f_s.illegal = 1'b1;
        imm_s       = imm_i_s;
      end
    endcase
  end

  assign fields  = f_s;
  assign imm     = imm_s;
  assign jtarget = jt_s;

endmodule

// File: rtl/instr_decode_stage.sv
// MIPS-32 decode stage: decodes on entry, then holds up to two decoded
// entries in a head/tail skid buffer so outputs come straight from registers.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CNT_W          = 16,
  parameter int ZERO_EXT_LOGIC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [5:0]       opcode,
  output logic [4:0]       src1,
  output logic [4:0]       src2,
  output logic [4:0]       dest,
  output logic [4:0]       shamt,
  output logic [5:0]       funct,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  jtarget,
  output logic [1:0]       fmt,
  output logic             writes_reg,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_cnt
);

  // Entry layout: {fields, imm, jtarget, pc}
  localparam int ENT_W = DEC_W + 3 * XLEN;

  logic [DEC_W-1:0] dec_fields_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [XLEN-1:0]  dec_jt_s;
  logic [ENT_W-1:0] new_ent_s;

  logic [ENT_W-1:0] head_r;
  logic [ENT_W-1:0] tail_r;
  logic [1:0]       count_r;
  logic [CNT_W-1:0] cnt_r;

  logic [ENT_W-1:0] head_nxt_s;
  logic [ENT_W-1:0] tail_nxt_s;
  logic [1:0]       count_nxt_s;
  logic             push_s;
  logic             pop_s;
  dec_fields_t      head_f_s;

  instr_decode_comb #(
    .XLEN          (XLEN),
    .ZERO_EXT_LOGIC(ZERO_EXT_LOGIC)
  ) u_decode (
    .instr  (in_instr),
    .pc     (in_pc),
    .fields (dec_fields_s),
    .imm    (dec_imm_s),
    .jtarget(dec_jt_s)
  );

  assign new_ent_s = {dec_fields_s, dec_imm_s, dec_jt_s, in_pc};

  assign in_ready  = ~reset & (count_r != 2'd2);
  assign out_valid = (count_r != 2'd0);
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;

  // Buffer next state; the head register always holds the oldest entry.
  always_comb begin
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    case (count_r)
      2'd0: begin
        if (push_s) begin
          head_nxt_s  = new_ent_s;
          count_nxt_s = 2'd1;
        end else begin
          count_nxt_s = 2'd0;
        end
      end
      2'd1: begin
        if (push_s && pop_s) begin
          head_nxt_s  = new_ent_s;
          count_nxt_s = 2'd1;
        end else if (push_s) begin
          tail_nxt_s  = new_ent_s;
          count_nxt_s = 2'd2;
        end else if (pop_s) begin
          count_nxt_s = 2'd0;
        end else begin
          count_nxt_s = 2'd1;
        end
      end
      2'd2: begin
        // in_ready is low when full, so only a pop can happen here.
        if (pop_s) begin
          head_nxt_s  = tail_r;
          count_nxt_s = 2'd1;
        end else begin
          count_nxt_s = 2'd2;
        end
      end
      default: begin
        count_nxt_s = 2'd0;
      end
    endcase
  end

  // Buffer and accepted-instruction counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= 2'd0;
      cnt_r   <= '0;
    end else begin
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
      if (push_s) begin
        cnt_r <= cnt_r + CNT_W'(1'b1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign head_f_s   = head_r[ENT_W-1 -: DEC_W];
  assign imm        = head_r[3*XLEN-1 -: XLEN];
  assign jtarget    = head_r[2*XLEN-1 -: XLEN];
  assign out_pc     = head_r[XLEN-1:0];
  assign opcode     = head_f_s.opcode;
  assign src1       = head_f_s.src1;
  assign src2       = head_f_s.src2;
  assign dest       = head_f_s.dest;
  assign shamt      = head_f_s.shamt;
  assign funct      = head_f_s.funct;
  assign fmt        = head_f_s.fmt;
  assign writes_reg = head_f_s.writes_reg;
  assign illegal    = head_f_s.illegal;
  assign decode_cnt = cnt_r;

endmodule
